// File: rtl/ms_jk_drv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ms_jk_drv_pkg
//  Brief    : Shared types and JK drive codes for the master-slave JK driver.
//             The drive codes are packed as {j, k}.
//  Revision : 1.0 - initial release
// ============================================================================
package ms_jk_drv_pkg;

    // Sequencer states. Each pattern bit takes one DRIVE and one CHECK cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // JK excitation codes, bit 1 = J, bit 0 = K.
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage : ms_jk_drv_pkg
`default_nettype wire

// File: rtl/jk_excite.sv
`default_nettype none
// ============================================================================
//  Module   : jk_excite
//  Brief    : Combinational JK excitation: the J/K pair that moves a JK
//             flip-flop from its current Q to the target t in one edge.
//             Macro JK_TOGGLE_EN selects the toggle code for any change
//             instead of the explicit set/reset codes.
//  Revision : 1.0 - initial release
// ============================================================================
module jk_excite
    import ms_jk_drv_pkg::*;
(
    input  logic       t,
    input  logic       q,
    output logic [1:0] jk
);

    // Pick the excitation code; equal target and state always holds.
    always_comb begin
        jk = JK_HOLD;
        if (t != q) begin
`ifdef JK_TOGGLE_EN
            jk = JK_TOGGLE;
`else
            jk = t ? JK_SET : JK_RESET;
`endif
        end
    end

endmodule : jk_excite
`default_nettype wire

// File: rtl/ms_jk_driver.sv
`default_nettype none
// ============================================================================
//  Module   : ms_jk_driver
//  Brief    : Drives a WIDTH-bit target sequence, LSB first, into an external
//             master-slave JK flip-flop. Each bit spends one DRIVE cycle with
//             J/K applied and one CHECK cycle with J/K held at zero, during
//             which Q is compared against the target. Differences are counted
//             in mismatch_cnt (saturating at WIDTH) and flagged on err.
//             Excitation style is chosen by macro JK_TOGGLE_EN in jk_excite.
//  Revision : 1.0 - initial release
// ============================================================================
module ms_jk_driver
    import ms_jk_drv_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WIDTH-1:0]           pattern,
    input  logic                       q_fb,
    output logic                       j,
    output logic                       k,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(WIDTH+1)-1:0] mismatch_cnt,
    output logic                       err
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH+1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);

    state_t             state_q;
    logic [WIDTH-1:0]   pattern_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   mismatch_cnt_q;
    logic               err_q;
    logic               j_q;
    logic               k_q;
    logic               busy_q;
    logic               done_q;

    logic [IDX_W-1:0]   idx_d;
    logic [CNT_W-1:0]   mismatch_cnt_d;
    logic               target_d;
    logic               bit_miss;
    logic [1:0]         jk_d;

    // Next index, target bit for the upcoming DRIVE and the updated counter.
    // In IDLE the target is bit 0 of the live pattern, since it is captured
    // on the same edge that registers the first J/K pair.
    always_comb begin
        idx_d          = idx_q + IDX_W'(1);
        target_d       = pattern_q[idx_d];
        bit_miss       = q_fb ^ pattern_q[idx_q];
        mismatch_cnt_d = mismatch_cnt_q;
        if (state_q == IDLE) begin
            target_d = pattern[0];
        end
        if (bit_miss && (mismatch_cnt_q != CNT_MAX)) begin
            mismatch_cnt_d = mismatch_cnt_q + CNT_W'(1);
        end
    end

    jk_excite u_jk_excite (
        .t  (target_d),
        .q  (q_fb),
        .jk (jk_d)
    );

    // Run sequencer; J/K default to hold so each bit sees exactly one
    // capture edge with a non-hold code.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            pattern_q      <= '0;
            idx_q          <= '0;
            mismatch_cnt_q <= '0;
            err_q          <= 1'b0;
            j_q            <= 1'b0;
            k_q            <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            j_q    <= 1'b0;
            k_q    <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q        <= DRIVE;
                        pattern_q      <= pattern;
                        idx_q          <= '0;
                        mismatch_cnt_q <= '0;
                        err_q          <= 1'b0;
                        busy_q         <= 1'b1;
                        j_q            <= jk_d[1];
                        k_q            <= jk_d[0];
                    end
                end
                DRIVE: begin
                    state_q <= CHECK;
                end
                CHECK: begin
                    mismatch_cnt_q <= mismatch_cnt_d;
                    err_q          <= (mismatch_cnt_d != '0);
                    if (idx_q != IDX_LAST) begin
                        state_q <= DRIVE;
                        idx_q   <= idx_d;
                        j_q     <= jk_d[1];
                        k_q     <= jk_d[0];
                    end else begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign j            = j_q;
    assign k            = k_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign mismatch_cnt = mismatch_cnt_q;
    assign err          = err_q;

endmodule : ms_jk_driver
`default_nettype wire

// File: tb/tb_ms_jk_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ms_jk_driver
//  Brief    : Self-checking bench for ms_jk_driver (WIDTH=8) driving a
//             behavioural master-slave JK flip-flop. Honours JK_TOGGLE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ms_jk_driver;

    localparam int WIDTH = 8;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic       q_fb;
    logic       j;
    logic       k;
    logic       busy;
    logic       done;
    logic [3:0] mismatch_cnt;
    logic       err;

    // Behavioural JK flip-flop and a tie-low override for q_fb.
    logic       q_mdl;
    logic       mdl_clr;
    logic       tie0;

    int n_checks;
    int n_errors;

    typedef struct packed {
        logic [3:0] cnt;
        logic       err;
        logic [7:0] done_edge;
    } res_t;

    logic [1:0] jk_exp_q[$];
    logic       q_exp_q[$];
    res_t       res_q[$];

    ms_jk_driver #(.WIDTH(WIDTH)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .pattern      (pattern),
        .q_fb         (q_fb),
        .j            (j),
        .k            (k),
        .busy         (busy),
        .done         (done),
        .mismatch_cnt (mismatch_cnt),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Master-slave JK: the new Q appears after the capturing rising edge.
    always @(posedge clk) begin
        if (mdl_clr) begin
            q_mdl <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q_mdl <= 1'b0;
                2'b10:   q_mdl <= 1'b1;
                2'b11:   q_mdl <= ~q_mdl;
                default: q_mdl <= q_mdl;
            endcase
        end
    end

    assign q_fb = tie0 ? 1'b0 : q_mdl;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_jk(input logic t, input logic q);
        if (t == q) return 2'b00;
`ifdef JK_TOGGLE_EN
        return 2'b11;
`else
        return t ? 2'b10 : 2'b01;
`endif
    endfunction

    // One run: pushes expectations at start, then walks 25 edges after the
    // start edge comparing against popped entries. re_edge injects a second
    // start pulse, rst_edge a one-edge reset (negative = none).
    task automatic run(input logic [7:0] pat, input bit tie,
                       input int re_edge, input int rst_edge);
        int   mis;
        logic qm;
        int   done_edge;
        int   n_done;
        res_t r;

        tie0    = tie;
        mdl_clr = 1'b1;
        @(posedge clk); #1;
        mdl_clr = 1'b0;

        mis = 0;
        qm  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            jk_exp_q.push_back(exp_jk(pat[i], qm));
            if (!tie) q_exp_q.push_back(pat[i]);
            if (tie && pat[i]) mis++;
            qm = tie ? 1'b0 : pat[i];
        end
        if (rst_edge < 0) res_q.push_back({4'(mis), (mis != 0), 8'd16});

        pattern = pat;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        pattern = ~pat;

        done_edge = -1;
        n_done    = 0;
        for (int e = 0; e <= 24; e++) begin
            if (e == 0) begin
                chk("busy_on_start", busy, 1);
                chk("cnt_clear_on_start", mismatch_cnt, 0);
            end
            if (rst_edge >= 0 && e == rst_edge) begin
                chk("rst_busy", busy, 0);
                chk("rst_jk", {j, k}, 0);
                chk("rst_cnt", mismatch_cnt, 0);
                chk("rst_err", err, 0);
            end
            if (done) begin
                n_done++;
                if (done_edge < 0) done_edge = e;
            end
            if (done_edge >= 0 && e == done_edge + 1) begin
                chk("done_one_cycle", done, 0);
                chk("idle_busy", busy, 0);
            end
            if (e < 16 && (rst_edge < 0 || e < rst_edge)) begin
                if ((e % 2) == 0) begin
                    chk($sformatf("jk_drive_b%0d", e / 2), {j, k}, jk_exp_q.pop_front());
                end else begin
                    chk("jk_hold_check", {j, k}, 0);
                    if (q_exp_q.size() > 0)
                        chk($sformatf("q_seq_b%0d", e / 2), q_fb, q_exp_q.pop_front());
                end
            end
            start = (e + 1 == re_edge);
            if (start) pattern = 8'h3C;
            rst   = !(e + 1 == rst_edge);
            @(posedge clk); #1;
        end
        start = 1'b0;
        rst   = 1'b1;
        jk_exp_q.delete();
        q_exp_q.delete();

        if (rst_edge < 0) begin
            if (res_q.size() == 0) begin
                chk("result_queue_empty", 0, 1);
            end else begin
                r = res_q.pop_front();
                chk("done_edge", done_edge, int'(r.done_edge));
                chk("done_pulses", n_done, 1);
                chk("mismatch_cnt", mismatch_cnt, r.cnt);
                chk("err", err, r.err);
            end
        end else begin
            chk("no_done_after_rst", n_done, 0);
            chk("no_resume_busy", busy, 0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        start    = 1'b0;
        pattern  = 8'h00;
        tie0     = 1'b0;
        mdl_clr  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_j", j, 0);
        chk("reset_k", k, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_cnt", mismatch_cnt, 0);
        chk("reset_err", err, 0);
        rst     = 1'b1;
        mdl_clr = 1'b0;
        @(posedge clk); #1;

        // Nominal sequence, hold-only, all-ones (excitation style).
        run(8'hA5, 1'b0, -1, -1);
        run(8'h00, 1'b0, -1, -1);
        run(8'hFF, 1'b0, -1, -1);

        // Mismatch counting with Q stuck low; result must persist.
        run(8'hF0, 1'b1, -1, -1);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_cnt", mismatch_cnt, 4);
        chk("hold_err", err, 1);

        // Reset during the bit-3 DRIVE cycle (state entered at edge 6).
        run(8'hFF, 1'b1, -1, 7);

        // Second start during a run is ignored.
        run(8'h5A, 1'b0, 5, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ms_jk_driver
`default_nettype wire
